// File: rtl/sum_bcd_convert_pkg.sv
// Shared definitions for the sum-to-BCD conversion stage.
//  - FSM state encodings
//  - BCD digit width
//  - default data width / digit count and the rule tying them together
package sum_bcd_convert_pkg;

  localparam int BCD_W     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NDIG  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // NDIG digits must be able to hold the largest magnitude, 2**(WIDTH+1)-2.
  function automatic bit ndig_ok(input int width, input int ndig);
    longint pow10;
    pow10 = 1;
    for (int i = 0; i < ndig; i++) begin
      pow10 = pow10 * 10;
    end
    return pow10 > ((longint'(1) << (width + 1)) - 2);
  endfunction

  localparam bit DEF_NDIG_OK = ndig_ok(DEF_WIDTH, DEF_NDIG);

endpackage

// File: rtl/sum_bcd_convert_if.sv
// Handshake/data bundle between the adder stage (master) and the BCD converter (slave).
//  start   : request conversion of res_in/cout_in/sub_in
//  res_in  : adder sum, cout_in: adder carry-out, sub_in: 0=add 1=subtract
//  busy    : conversion in progress
//  done    : one-cycle pulse, bcd/neg valid from this cycle
//  neg     : result negative
//  bcd     : NDIG packed BCD digits, ones in the low nibble
interface sum_bcd_convert_if
  import sum_bcd_convert_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDIG  = DEF_NDIG
);
  logic                    start;
  logic [WIDTH-1:0]        res_in;
  logic                    cout_in;
  logic                    sub_in;
  logic                    busy;
  logic                    done;
  logic                    neg;
  logic [BCD_W*NDIG-1:0]   bcd;

  modport master (
    output start, res_in, cout_in, sub_in,
    input  busy, done, neg, bcd
  );

  modport slave (
    input  start, res_in, cout_in, sub_in,
    output busy, done, neg, bcd
  );
endinterface

// File: rtl/sum_bcd_convert_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that the
// following left shift carries correctly into the next decade.
//  din  : BCD digit before correction
//  dout : corrected digit
module bcd_add3
  import sum_bcd_convert_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);
  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/sum_bcd_convert.sv
// Converts the registered adder/subtractor result to sign + BCD digits using an
// iterative shift-add-3 engine (one magnitude bit per clock).
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : slave side of sum_bcd_convert_if (start/busy/done handshake, inputs, results)
// A conversion takes WIDTH+1 shift cycles; bcd/neg hold the last completed result.
module sum_bcd_convert
  import sum_bcd_convert_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDIG  = DEF_NDIG
) (
  input  logic                clk,
  input  logic                rst_n,
  sum_bcd_convert_if.slave    bus
);
  localparam int MAG_W   = WIDTH + 1;
  localparam int BCD_TOT = BCD_W * NDIG;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  generate
    if (!ndig_ok(WIDTH, NDIG) || !DEF_NDIG_OK) begin : g_bad_ndig
      $error("NDIG too small to hold the largest magnitude for this WIDTH");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [BCD_TOT-1:0]   scr_q, scr_d;
  logic                 pend_neg_q, pend_neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 neg_q, neg_d;
  logic [BCD_TOT-1:0]   bcd_q, bcd_d;

  logic [BCD_TOT-1:0]   adj;
  logic [MAG_W-1:0]     mag_load;
  logic                 neg_load;
  logic [WIDTH-1:0]     res_twos;

  // Per-digit add-3 correction of the scratch register.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[gi*BCD_W +: BCD_W]),
      .dout (adj[gi*BCD_W +: BCD_W])
    );
  end

  // Signed magnitude of the incoming result. A subtract without carry-out is a
  // borrow, so the true magnitude is the two's complement of the sum.
  always_comb begin
    res_twos = ~bus.res_in + WIDTH'(1);
    mag_load = {bus.cout_in, bus.res_in};
    neg_load = 1'b0;
    if (bus.sub_in) begin
      if (bus.cout_in) begin
        mag_load = {1'b0, bus.res_in};
      end else begin
        mag_load = {1'b0, res_twos};
        neg_load = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    scr_d      = scr_q;
    pend_neg_d = pend_neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    neg_d      = neg_q;
    bcd_d      = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mag_d      = mag_load;
          scr_d      = '0;
          cnt_d      = '0;
          pend_neg_d = neg_load;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // {scratch, mag} shifted left by one after digit correction; the top
        // corrected bit is always zero because NDIG covers the full range.
        scr_d = BCD_TOT'({adj, mag_q[MAG_W-1]});
        mag_d = {mag_q[MAG_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH)) begin
          bcd_d   = scr_d;
          neg_d   = pend_neg_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      scr_q      <= '0;
      pend_neg_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scr_q      <= scr_d;
      pend_neg_q <= pend_neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      neg_q      <= neg_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_sum_bcd_convert.sv
// Directed bench for sum_bcd_convert: expected sign/digits are pushed to a
// scoreboard at each start and compared when done pulses.
module tb_sum_bcd_convert;
  import sum_bcd_convert_pkg::*;

  localparam int WIDTH = 8;
  localparam int NDIG  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_bcd_convert_if #(.WIDTH(WIDTH), .NDIG(NDIG)) bus ();

  sum_bcd_convert #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] last_bcd = '0;
  logic        last_neg = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] r, input logic c, input logic s);
    exp_t e;
    int   v;
    if (!s) begin
      v = int'({c, r});
      e.neg = 1'b0;
    end else if (c) begin
      v = int'(r);
      e.neg = 1'b0;
    end else begin
      v = (256 - int'(r)) % 256;
      e.neg = 1'b1;
    end
    e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed done=1 expected no pending result");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("done_bcd", 32'(bus.bcd), 32'(mon_e.bcd));
        check("done_neg", 32'(bus.neg), 32'(mon_e.neg));
      end
    end
  end

  // Starts a conversion at the current negedge and follows it to its done cycle.
  task automatic conv(input logic [7:0] r, input logic c, input logic s, input bit retrig);
    exp_t e;
    e = model(r, c, s);
    bus.res_in  = r;
    bus.cout_in = c;
    bus.sub_in  = s;
    bus.start   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.res_in  = 8'($urandom);
    bus.cout_in = 1'($urandom);
    bus.sub_in  = 1'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_early", 32'(bus.done), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      bus.start = retrig && (i == 3 || i == 5);
      @(negedge clk);
      check("done_early", 32'(bus.done), 32'd0);
      check("busy_mid", 32'(bus.busy), 32'd1);
      check("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
      check("neg_hold", 32'(bus.neg), 32'(last_neg));
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("done_latency", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    $display("conv res=%h cout=%b sub=%b -> bcd=%h neg=%b (exp %h %b)",
             r, c, s, bus.bcd, bus.neg, e.bcd, e.neg);
    last_bcd = e.bcd;
    last_neg = e.neg;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    check("done_cleared", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("bcd_stable", 32'(bus.bcd), 32'(last_bcd));
    check("neg_stable", 32'(bus.neg), 32'(last_neg));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.res_in  = '0;
    bus.cout_in = 1'b0;
    bus.sub_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    conv(8'h2C, 1'b1, 1'b0, 1'b0); idle_chk();   // 200+100 = 300
    conv(8'hFE, 1'b1, 1'b0, 1'b0); idle_chk();   // 255+255 = 510
    conv(8'hFC, 1'b0, 1'b1, 1'b0); idle_chk();   // 5-9 = -4
    conv(8'h04, 1'b1, 1'b1, 1'b0); idle_chk();   // 9-5 = 4
    conv(8'h00, 1'b1, 1'b1, 1'b0); idle_chk();   // 0-0 = 0
    conv(8'h00, 1'b0, 1'b1, 1'b0); idle_chk();   // impossible borrow case: -0
    conv(8'h7B, 1'b0, 1'b0, 1'b1);               // 123 with start re-pulsed while busy
    conv(8'h63, 1'b0, 1'b0, 1'b0); idle_chk();   // back-to-back in the done cycle: 99

    // Reset in the middle of a conversion.
    bus.res_in  = 8'h99;
    bus.cout_in = 1'b1;
    bus.sub_in  = 1'b0;
    bus.start   = 1'b1;
    sb.push_back(model(8'h99, 1'b1, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_neg", 32'(bus.neg), 32'd0);
    void'(sb.pop_back());
    last_bcd = '0;
    last_neg = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(bus.done), 32'd0);
      check("idle_after_abort", 32'(bus.busy), 32'd0);
    end
    conv(8'hC8, 1'b0, 1'b0, 1'b0); idle_chk();   // 200 after recovery

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
